// File: rtl/counter_pkg.sv
// Shared constants and next-count step function for multimode_counter.
// next_count returns the stepped count plus wrap/saturation flags.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  typedef struct packed {
    logic [31:0] q;
    logic        wrap;
    logic        at_bound;
  } step_t;

  // q is zero-extended to 32 bits; modulus is 33 bits so that
  // 2**32 is representable and modulus-1 never overflows.
  function automatic step_t next_count(
    input logic [31:0] q,
    input logic        up_dn,
    input logic        sat,
    input logic [32:0] modulus
  );
    step_t       r;
    logic [32:0] last;
    r    = '0;
    last = modulus - 33'd1;
    if (up_dn == DIR_UP) begin
      if ({1'b0, q} == last) begin
        if (sat == MODE_SAT) begin
          r.q        = q;
          r.at_bound = 1'b1;
        end else begin
          r.q    = '0;
          r.wrap = 1'b1;
        end
      end else begin
        r.q = q + 32'd1;
      end
    end else begin
      if (q == 32'd0) begin
        if (sat == MODE_SAT) begin
          r.q        = q;
          r.at_bound = 1'b1;
        end else begin
          r.q    = last[31:0];
          r.wrap = 1'b1;
        end
      end else begin
        r.q = q - 32'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2gray.sv
// Combinational binary-to-Gray converter.
// Ports: bin (binary in), gray (bin ^ (bin >> 1)).
module bin2gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/multimode_counter.sv
// Up/down wrap-or-saturate modulo counter with load and status pulses.
// Ports: clk, rst (async high), en, up_dn, sat, load, load_val -> q, tc,
// wrap, at_bound; q_gray only when MULTIMODE_COUNTER_GRAY_EN is defined.
module multimode_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH   = 4,
  parameter longint MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             at_bound
`ifdef MULTIMODE_COUNTER_GRAY_EN
  ,
  output logic [WIDTH-1:0] q_gray
`endif
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "multimode_counter: WIDTH out of range 2..32");
  end

  if (MODULUS < 2 || MODULUS > (64'sd1 <<< WIDTH)) begin : g_bad_mod
    $fatal(1, "multimode_counter: MODULUS out of range 2..2**WIDTH");
  end

  localparam logic [32:0]      MOD  = 33'(MODULUS);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  step_t            nc;
  logic [WIDTH-1:0] q_d;
  logic             wrap_d;
  logic             bound_d;

  assign nc = next_count(32'(q), up_dn, sat, MOD);

  // Stepped value is always < MODULUS <= 2**WIDTH, so the upper bits
  // of nc.q are zero and truncation is lossless.
  if (WIDTH < 32) begin : g_trunc
    logic unused;
    assign unused = ^nc.q[31:WIDTH];
  end

  always_comb begin
    q_d     = q;
    wrap_d  = 1'b0;
    bound_d = 1'b0;
    if (load) begin
      q_d = (64'(load_val) >= MODULUS) ? LAST : load_val;
    end else if (en) begin
      q_d     = nc.q[WIDTH-1:0];
      wrap_d  = nc.wrap;
      bound_d = nc.at_bound;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q        <= '0;
      wrap     <= 1'b0;
      at_bound <= 1'b0;
    end else begin
      q        <= q_d;
      wrap     <= wrap_d;
      at_bound <= bound_d;
    end
  end

  assign tc = (up_dn == DIR_UP) ? (q == LAST) : (q == '0);

`ifdef MULTIMODE_COUNTER_GRAY_EN
  logic [WIDTH-1:0] gray_d;

  // Register Gray of the next count so q_gray tracks q cycle for cycle.
  bin2gray #(.WIDTH(WIDTH)) u_gray (
    .bin  (q_d),
    .gray (gray_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_gray <= '0;
    else     q_gray <= gray_d;
  end
`endif

endmodule

// File: tb/tb_multimode_counter.sv
// Bench: two counters (MODULUS 10 and 16) driven by shared stimulus,
// checked against arithmetic models plus literal expectations.
module tb_multimode_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       sat = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;

  logic [3:0] q10, q16;
  logic       tc10, tc16, w10, w16, b10, b16;
`ifdef MULTIMODE_COUNTER_GRAY_EN
  logic [3:0] g10, g16;
`endif

  int vectors = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multimode_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat(sat),
    .load(load), .load_val(load_val),
    .q(q10), .tc(tc10), .wrap(w10), .at_bound(b10)
`ifdef MULTIMODE_COUNTER_GRAY_EN
    , .q_gray(g10)
`endif
  );

  multimode_counter dut16 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat(sat),
    .load(load), .load_val(load_val),
    .q(q16), .tc(tc16), .wrap(w16), .at_bound(b16)
`ifdef MULTIMODE_COUNTER_GRAY_EN
    , .q_gray(g16)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain modular arithmetic on integers.
  int m10 = 0, m16 = 0, p16 = 0;
  int mw10 = 0, mw16 = 0, mb10 = 0, mb16 = 0;

  task automatic model(input int m, inout int mq, output int w, output int b);
    w = 0;
    b = 0;
    if (load) begin
      mq = (int'(load_val) >= m) ? m - 1 : int'(load_val);
    end else if (en) begin
      if (up_dn) begin
        if (sat && mq == m - 1) b = 1;
        else begin
          w  = (mq == m - 1) ? 1 : 0;
          mq = (mq + 1) % m;
        end
      end else begin
        if (sat && mq == 0) b = 1;
        else begin
          w  = (mq == 0) ? 1 : 0;
          mq = (mq + m - 1) % m;
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    p16 = m16;
    if (rst) begin
      m10 = 0; m16 = 0; mw10 = 0; mw16 = 0; mb10 = 0; mb16 = 0;
    end else begin
      model(10, m10, mw10, mb10);
      model(16, m16, mw16, mb16);
    end
  end

  always @(negedge clk) begin
    chk("q10", int'(q10), m10);
    chk("wrap10", int'(w10), mw10);
    chk("bound10", int'(b10), mb10);
    chk("tc10", int'(tc10), up_dn ? int'(m10 == 9) : int'(m10 == 0));
    chk("q16", int'(q16), m16);
    chk("wrap16", int'(w16), mw16);
    chk("bound16", int'(b16), mb16);
    chk("tc16", int'(tc16), up_dn ? int'(m16 == 15) : int'(m16 == 0));
`ifdef MULTIMODE_COUNTER_GRAY_EN
    chk("gray10", int'(g10), m10 ^ (m10 >> 1));
    chk("gray16", int'(g16), m16 ^ (m16 >> 1));
    if (!rst && (m16 == (p16 + 1) % 16 || p16 == (m16 + 1) % 16))
      chk("gray16_step", $countones(g16 ^ 4'(p16 ^ (p16 >> 1))), 1);
`endif
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int e31[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int e32[4] = '{1, 0, 0, 0};
  int b32[4] = '{0, 0, 1, 1};

  initial begin
    #1 rst = 1'b1;
    tick;
    tick;
    chk("rst_q", int'(q10), 0);
    chk("rst_flags", int'({w10, b10}), 0);
    rst = 1'b0;

    en = 1'b1; up_dn = 1'b1; sat = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick;
      chk("up_wrap_q", int'(q10), e31[i]);
      chk("up_wrap_pulse", int'(w10), (i == 9) ? 1 : 0);
    end

    load = 1'b1; load_val = 4'd2;
    tick;
    chk("load_beats_en", int'(q10), 2);
    load = 1'b0; up_dn = 1'b0; sat = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("sat_dn_q", int'(q10), e32[i]);
      chk("sat_dn_bound", int'(b10), b32[i]);
      chk("sat_dn_wrap", int'(w10), 0);
    end

    load = 1'b1; load_val = 4'd15; up_dn = 1'b1; en = 1'b0;
    tick;
    chk("clamp_q", int'(q10), 9);
    chk("clamp_tc", int'(tc10), 1);
    chk("noclamp_q16", int'(q16), 15);
    load = 1'b0; en = 1'b1;
    tick;
    chk("sat_up_q", int'(q10), 9);
    chk("sat_up_bound", int'(b10), 1);

    sat = 1'b0; load = 1'b1; load_val = 4'd7;
    tick;
    chk("pre_rst_q", int'(q10), 7);
    #2;
    rst = 1'b1; load_val = 4'd5;
    #1;
    chk("async_rst_q", int'(q10), 0);
    chk("async_rst_flags", int'({w10, b10}), 0);
    tick;
    chk("rst_ignores_load", int'(q10), 0);
    rst = 1'b0; load = 1'b0; en = 1'b1; up_dn = 1'b1;
    tick;
    chk("first_after_rst", int'(q10), 1);

    for (int i = 0; i < 60; i++) begin
      if (i % 3 == 0 && i > 0) up_dn = ~up_dn;
      en = 1'($urandom_range(0, 1));
      sat = (i >= 30);
      tick;
    end

    en = 1'b1; up_dn = 1'b1; sat = 1'b0;
    repeat (20) tick;

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/multimode_counter.md
MULTIMODE_COUNTER -- requirements
Module: multimode_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 2..32.
REQ-002 Parameter MODULUS, default 16: count range 0..MODULUS-1; legal range 2..2**WIDTH.
REQ-003 Port clk, input, 1: single clock, all state updates on rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port en, input, 1: count enable.
REQ-006 Port up_dn, input, 1: direction, 1 = up, 0 = down.
REQ-007 Port sat, input, 1: mode, 1 = saturate at bound, 0 = wrap modulo MODULUS.
REQ-008 Port load, input, 1: synchronous load strobe.
REQ-009 Port load_val, input, WIDTH: value to load.
REQ-010 Port q, output, WIDTH: current count, registered.
REQ-011 Port tc, output, 1: terminal count, combinational from q and up_dn.
REQ-012 Port wrap, output, 1: registered one-cycle pulse, count wrapped on previous edge.
REQ-013 Port at_bound, output, 1: registered; count held at bound by saturation on previous edge.

Function
REQ-014 Priority per edge SHALL be rst > load > en; en=0 and load=0 holds q, clears wrap and at_bound.
REQ-015 load=1 SHALL set q to load_val next edge, clamped to MODULUS-1 when load_val >= MODULUS; wrap and at_bound SHALL be 0 that cycle.
REQ-016 en=1, up_dn=1, q < MODULUS-1 SHALL give q+1 next edge.
REQ-017 en=1, up_dn=0, q > 0 SHALL give q-1 next edge.
REQ-018 Up at q = MODULUS-1 with sat=0 SHALL give q = 0 and wrap = 1 next edge.
REQ-019 Down at q = 0 with sat=0 SHALL give q = MODULUS-1 and wrap = 1 next edge.
REQ-020 Count at bound with sat=1 SHALL hold q, assert at_bound = 1 next edge, wrap = 0.
REQ-021 tc SHALL be 1 iff (up_dn=1 and q = MODULUS-1) or (up_dn=0 and q = 0), independent of en.
REQ-022 Changing up_dn or sat between edges SHALL take effect at the next edge with no extra latency.
REQ-023 Arithmetic SHALL be on WIDTH bits; no intermediate overflow when MODULUS = 2**WIDTH.

Reset
REQ-024 rst=1 SHALL immediately force q = 0, wrap = 0, at_bound = 0, without waiting for clk.
REQ-025 rst asserted mid-count SHALL discard any simultaneous load or en; first count after release is from 0 on first rising edge with rst=0.

Configuration
REQ-026 Macro MULTIMODE_COUNTER_GRAY_EN defined SHALL add output port q_gray, WIDTH, registered, equal to Gray(q) in the same cycle as q (q ^ (q >> 1)).
REQ-027 MULTIMODE_COUNTER_GRAY_EN undefined SHALL omit q_gray and all Gray logic; remaining behaviour identical.

Structure
REQ-028 Shared package counter_pkg SHALL hold direction constants (DIR_UP, DIR_DOWN), mode constants (MODE_WRAP, MODE_SAT) and function next_count(q, up_dn, sat, modulus).
REQ-029 Sub-module bin2gray (parameter WIDTH, combinational) SHALL be instantiated only under MULTIMODE_COUNTER_GRAY_EN.
REQ-030 Parameter legality (REQ-001, REQ-002) SHALL be checked at elaboration with a fatal error.

Verification
REQ-031 WIDTH=4, MODULUS=10, sat=0, up: 12 enabled edges from reset -> q 1..9,0,1,2; wrap=1 only in the cycle after q=9 -> 0.
REQ-032 WIDTH=4, MODULUS=10, sat=1, down from load_val=2: 4 edges -> q 1,0,0,0; at_bound=1 from the third edge; wrap never 1.
REQ-033 load=1 with load_val=15, MODULUS=10 -> q=9, tc=1 with up_dn=1; load and en together -> load wins.
REQ-034 rst pulse asserted between edges while q=7 -> q=0 before next edge; wrap and at_bound=0.
REQ-035 Default parameters, up_dn toggled every 3 edges, random en -> q matches next_count reference model every cycle.
REQ-036 With MULTIMODE_COUNTER_GRAY_EN, full wrap cycle at WIDTH=4, MODULUS=16 -> q_gray changes exactly one bit per count, including 15 -> 0.
